// File: rtl/channel_window_averager_pkg.sv
// Shared definitions for the channel window averager: default sizing,
// channel-index type and the flush FSM state encoding.
package channel_window_averager_pkg;

    localparam int NUM_CH   = 7;
    localparam int SAMPLE_W = 8;
    localparam int WINDOW   = 10;
    localparam int CNT_W    = $clog2(WINDOW + 1);
    localparam int PTR_W    = $clog2(WINDOW);
    localparam int SUM_W    = SAMPLE_W + CNT_W;
    localparam int CH_W     = 3;

    typedef logic [CH_W-1:0] ch_t;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/window_mean_div.sv
// window_mean_div: floor(sum / cnt) for cnt in 1..WINDOW, 0 when cnt == 0.
// Purely combinational. Because the divisor only takes WINDOW distinct values,
// each candidate is a divide by a constant and the count selects the result.
// Ports:
//   sum  in  SUM_W     window sum (never exceeds cnt * max sample)
//   cnt  in  CNT_W     number of samples in the window
//   mean out SAMPLE_W  floor mean
module window_mean_div
    import channel_window_averager_pkg::*;
(
    input  logic [SUM_W-1:0]    sum,
    input  logic [CNT_W-1:0]    cnt,
    output logic [SAMPLE_W-1:0] mean
);

    logic [SAMPLE_W-1:0] quot_s;

    // Select the constant-divisor quotient that matches the current count.
    always_comb begin
        quot_s = {SAMPLE_W{1'b0}};
        for (int d = 1; d <= WINDOW; d++) begin
            quot_s = (cnt == CNT_W'(d)) ? SAMPLE_W'(sum / SUM_W'(d)) : quot_s;
        end
    end

    assign mean = quot_s;

endmodule

// File: rtl/channel_window_averager.sv
// channel_window_averager: per-channel sliding window (last WINDOW samples)
// with running sum and floor mean, one result per accepted legal sample.
// Ports:
//   clk, rst_n          clock (posedge) and synchronous active-low reset
//   ena                 enable; when low no samples are accepted
//   clear               pulse that starts a flush of all channel windows
//   in_valid/in_ready   sample handshake; in_ch, in_sample carry the sample
//   out_valid           one-cycle pulse per accepted legal sample
//   out_ch/out_sum/out_mean/out_full  result of that sample, held otherwise
//   err_ch              sticky flag: an out-of-range channel was offered
module channel_window_averager
    import channel_window_averager_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                clear,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CH_W-1:0]     in_ch,
    input  logic [SAMPLE_W-1:0] in_sample,
    output logic                out_valid,
    output logic [CH_W-1:0]     out_ch,
    output logic [SUM_W-1:0]    out_sum,
    output logic [SAMPLE_W-1:0] out_mean,
    output logic                out_full,
    output logic                err_ch
);

    state_t state_r;
    state_t state_nxt_s;
    ch_t    clr_idx_r;
    ch_t    clr_idx_nxt_s;
    logic   in_ready_s;

    logic [SUM_W-1:0]    sum_r  [NUM_CH];
    logic [CNT_W-1:0]    cnt_r  [NUM_CH];
    logic [PTR_W-1:0]    wptr_r [NUM_CH];
    logic [SAMPLE_W-1:0] hist_r [NUM_CH][WINDOW];

    logic                accept_s;
    logic                legal_s;
    ch_t                 ch_idx_s;
    logic [SUM_W-1:0]    cur_sum_s;
    logic [CNT_W-1:0]    cur_cnt_s;
    logic [PTR_W-1:0]    cur_wptr_s;
    logic                cur_full_s;
    logic [SAMPLE_W-1:0] old_s;
    logic [SUM_W-1:0]    new_sum_s;
    logic [CNT_W-1:0]    new_cnt_s;
    logic [PTR_W-1:0]    new_wptr_s;

    logic                out_valid_r;
    ch_t                 out_ch_r;
    logic [SUM_W-1:0]    out_sum_r;
    logic [CNT_W-1:0]    out_cnt_r;
    logic                out_full_r;
    logic                err_ch_r;

    // Flush FSM next-state and handshake; clear blocks the same-cycle sample.
    always_comb begin
        state_nxt_s   = state_r;
        clr_idx_nxt_s = clr_idx_r;
        in_ready_s    = 1'b0;
        case (state_r)
            ST_RUN: begin
                in_ready_s = ena & ~clear;
                if (clear) begin
                    state_nxt_s   = ST_CLEAR;
                    clr_idx_nxt_s = ch_t'(0);
                end else begin
                    state_nxt_s   = ST_RUN;
                end
            end
            ST_CLEAR: begin
                if (clr_idx_r == ch_t'(NUM_CH - 1)) begin
                    state_nxt_s   = ST_RUN;
                    clr_idx_nxt_s = ch_t'(0);
                end else begin
                    clr_idx_nxt_s = clr_idx_r + ch_t'(1);
                end
            end
            default: begin
                state_nxt_s   = ST_RUN;
                clr_idx_nxt_s = ch_t'(0);
            end
        endcase
    end

    // Flush FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_RUN;
            clr_idx_r <= ch_t'(0);
        end else begin
            state_r   <= state_nxt_s;
            clr_idx_r <= clr_idx_nxt_s;
        end
    end

    // Window update arithmetic for the channel addressed by the incoming sample.
    // Illegal channels are steered to index 0 only to keep the reads in range;
    // the result is discarded for them.
    always_comb begin
        accept_s   = in_valid & in_ready_s;
        legal_s    = (in_ch < ch_t'(NUM_CH));
        ch_idx_s   = legal_s ? in_ch : ch_t'(0);
        cur_sum_s  = sum_r[ch_idx_s];
        cur_cnt_s  = cnt_r[ch_idx_s];
        cur_wptr_s = wptr_r[ch_idx_s];
        cur_full_s = (cur_cnt_s == CNT_W'(WINDOW));
        old_s      = cur_full_s ? hist_r[ch_idx_s][cur_wptr_s] : {SAMPLE_W{1'b0}};
        new_sum_s  = cur_sum_s + SUM_W'(in_sample) - SUM_W'(old_s);
        new_cnt_s  = cur_full_s ? cur_cnt_s : cur_cnt_s + CNT_W'(1);
        new_wptr_s = (cur_wptr_s == PTR_W'(WINDOW - 1)) ? PTR_W'(0)
                                                        : cur_wptr_s + PTR_W'(1);
    end

    // Per-channel sum/count/pointer, result registers and sticky error flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                sum_r[c]  <= {SUM_W{1'b0}};
                cnt_r[c]  <= {CNT_W{1'b0}};
                wptr_r[c] <= {PTR_W{1'b0}};
            end
            out_valid_r <= 1'b0;
            out_ch_r    <= ch_t'(0);
            out_sum_r   <= {SUM_W{1'b0}};
            out_cnt_r   <= {CNT_W{1'b0}};
            out_full_r  <= 1'b0;
            err_ch_r    <= 1'b0;
        end else begin
            out_valid_r <= 1'b0;
            if (state_r == ST_CLEAR) begin
                sum_r[clr_idx_r]  <= {SUM_W{1'b0}};
                cnt_r[clr_idx_r]  <= {CNT_W{1'b0}};
                wptr_r[clr_idx_r] <= {PTR_W{1'b0}};
            end else if (accept_s && legal_s) begin
                sum_r[ch_idx_s]  <= new_sum_s;
                cnt_r[ch_idx_s]  <= new_cnt_s;
                wptr_r[ch_idx_s] <= new_wptr_s;
                out_valid_r      <= 1'b1;
                out_ch_r         <= ch_idx_s;
                out_sum_r        <= new_sum_s;
                out_cnt_r        <= new_cnt_s;
                out_full_r       <= (new_cnt_s == CNT_W'(WINDOW));
            end else if (accept_s) begin
                err_ch_r <= 1'b1;
            end
        end
    end

    // Sample history; stale contents are harmless because the count gates reads.
    always_ff @(posedge clk) begin
        if (rst_n && accept_s && legal_s) begin
            hist_r[ch_idx_s][cur_wptr_s] <= in_sample;
        end
    end

    window_mean_div u_mean_div (
        .sum  (out_sum_r),
        .cnt  (out_cnt_r),
        .mean (out_mean)
    );

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_ch    = out_ch_r;
    assign out_sum   = out_sum_r;
    assign out_full  = out_full_r;
    assign err_ch    = err_ch_r;

endmodule
